// File: rtl/pipe_ctrl.sv
`default_nettype none
// pipe_ctrl: stall/flush controller for a 5-stage pipeline (bus wait, mul/div occupancy, redirect, trap drain).
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.  Rev 1.0
module pipe_ctrl #(
   parameter int MD_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        load_use,
   input  logic        ex_md,
   input  logic        ex_redirect,
   input  logic        trap,
   output logic        pc_hold,
   output logic        md_done,
   output logic [1:0]  stall_if_id,
   output logic [1:0]  stall_id_ex,
   output logic [1:0]  stall_ex_me,
   output logic [1:0]  stall_me_wb,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam logic [1:0] C_NEXT = 2'b00;
   localparam logic [1:0] C_KEEP = 2'b01;
   localparam logic [1:0] C_ZERO = 2'b10;
   localparam logic [3:0] C_MD_LOAD = 4'(MD_LAT - 1);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_MD_WAIT  = 2'd2,
      S_DRAIN    = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_md_cnt;
   logic [3:0] w_md_cnt_nxt;
   logic       w_mem_stall;

   assign w_mem_stall = mem_req & ~mem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      pc_hold      = 1'b0;
      md_done      = 1'b0;
      stall_if_id  = C_NEXT;
      stall_id_ex  = C_NEXT;
      stall_ex_me  = C_NEXT;
      stall_me_wb  = C_NEXT;

      if (rst) begin
         pc_hold      = 1'b1;
         stall_if_id  = C_ZERO;
         stall_id_ex  = C_ZERO;
         stall_ex_me  = C_ZERO;
         stall_me_wb  = C_ZERO;
         w_state_nxt  = S_RUN;
         w_md_cnt_nxt = '0;
      end else if (trap) begin
         // Flush everything; an outstanding bus access must still be drained.
         stall_if_id  = C_ZERO;
         stall_id_ex  = C_ZERO;
         stall_ex_me  = C_ZERO;
         stall_me_wb  = C_ZERO;
         w_md_cnt_nxt = '0;
         w_state_nxt  = w_mem_stall ? S_DRAIN : S_RUN;
      end else begin
         unique case (r_state)
            S_DRAIN: begin
               pc_hold     = 1'b1;
               stall_if_id = C_ZERO;
               stall_id_ex = C_ZERO;
               stall_ex_me = C_ZERO;
               stall_me_wb = C_ZERO;
               if (mem_ack) w_state_nxt = S_RUN;
            end
            S_MEM_WAIT: begin
               if (!mem_ack) begin
                  pc_hold     = 1'b1;
                  stall_if_id = C_KEEP;
                  stall_id_ex = C_KEEP;
                  stall_ex_me = C_KEEP;
                  stall_me_wb = C_ZERO;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            S_MD_WAIT: begin
               if (r_md_cnt != 4'd1) begin
                  pc_hold      = 1'b1;
                  stall_if_id  = C_KEEP;
                  stall_id_ex  = C_KEEP;
                  stall_ex_me  = C_ZERO;
                  w_md_cnt_nxt = r_md_cnt - 4'd1;
               end else begin
                  md_done      = 1'b1;
                  w_md_cnt_nxt = '0;
                  w_state_nxt  = S_RUN;
               end
            end
            default: begin
               if (w_mem_stall) begin
                  pc_hold     = 1'b1;
                  stall_if_id = C_KEEP;
                  stall_id_ex = C_KEEP;
                  stall_ex_me = C_KEEP;
                  stall_me_wb = C_ZERO;
                  w_state_nxt = S_MEM_WAIT;
               end else if (ex_md) begin
                  // The issue cycle counts as the first of the MD_LAT occupancy cycles.
                  pc_hold      = 1'b1;
                  stall_if_id  = C_KEEP;
                  stall_id_ex  = C_KEEP;
                  stall_ex_me  = C_ZERO;
                  w_md_cnt_nxt = C_MD_LOAD;
                  w_state_nxt  = S_MD_WAIT;
               end else if (ex_redirect) begin
                  stall_if_id = C_ZERO;
                  stall_id_ex = C_ZERO;
               end else if (load_use) begin
                  pc_hold     = 1'b1;
                  stall_if_id = C_KEEP;
                  stall_id_ex = C_ZERO;
               end
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;
   logic        w_flush;

   assign w_flush = trap | ((r_state == S_RUN) & ~w_mem_stall & ~ex_md & ex_redirect);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (pc_hold) r_perf_stall <= r_perf_stall + 32'd1;
         if (w_flush) r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_stall_cnt = rst ? '0 : r_perf_stall;
   assign perf_flush_cnt = rst ? '0 : r_perf_flush;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// tb_pipe_ctrl: directed vector table plus randomized run against a behavioural model of pipe_ctrl.
module tb_pipe_ctrl;

   localparam int MD_LAT = 4;
   localparam logic [1:0] N = 2'b00;
   localparam logic [1:0] K = 2'b01;
   localparam logic [1:0] Z = 2'b10;

   logic        clk = 1'b0;
   logic        rst, mem_req, mem_ack, load_use, ex_md, ex_redirect, trap;
   logic        pc_hold, md_done;
   logic [1:0]  stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;

   pipe_ctrl #(.MD_LAT(MD_LAT)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_ack(mem_ack),
      .load_use(load_use), .ex_md(ex_md), .ex_redirect(ex_redirect), .trap(trap),
      .pc_hold(pc_hold), .md_done(md_done),
      .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
      .stall_ex_me(stall_ex_me), .stall_me_wb(stall_me_wb),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic rst, mem_req, mem_ack, load_use, ex_md, ex_redirect, trap;
   } in_t;
   typedef struct packed {
      logic       pc_hold, md_done;
      logic [1:0] if_id, id_ex, ex_me, me_wb;
   } out_t;
   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Model: which multi-cycle activity is in progress and how long it has left.
   bit          m_mem_wait = 0, m_drain = 0;
   int          m_md_left = 0;
   logic [31:0] m_stall = '0, m_flush = '0;
   bit          nx_mem_wait, nx_drain;
   int          nx_md_left;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input in_t x, output out_t e, output bit fl);
      e = {1'b0, 1'b0, N, N, N, N};
      fl = 1'b0;
      nx_mem_wait = m_mem_wait;
      nx_drain    = m_drain;
      nx_md_left  = m_md_left;
      if (x.rst) begin
         e = {1'b1, 1'b0, Z, Z, Z, Z};
         nx_mem_wait = 0; nx_drain = 0; nx_md_left = 0;
      end else if (x.trap) begin
         e = {1'b0, 1'b0, Z, Z, Z, Z};
         fl = 1'b1;
         nx_mem_wait = 0; nx_md_left = 0;
         nx_drain = x.mem_req && !x.mem_ack;
      end else if (m_drain) begin
         e = {1'b1, 1'b0, Z, Z, Z, Z};
         if (x.mem_ack) nx_drain = 0;
      end else if (m_mem_wait) begin
         if (!x.mem_ack) e = {1'b1, 1'b0, K, K, K, Z};
         else nx_mem_wait = 0;
      end else if (m_md_left > 0) begin
         if (m_md_left == 1) begin
            e.md_done = 1'b1;
            nx_md_left = 0;
         end else begin
            e = {1'b1, 1'b0, K, K, Z, N};
            nx_md_left = m_md_left - 1;
         end
      end else if (x.mem_req && !x.mem_ack) begin
         e = {1'b1, 1'b0, K, K, K, Z};
         nx_mem_wait = 1;
      end else if (x.ex_md) begin
         e = {1'b1, 1'b0, K, K, Z, N};
         nx_md_left = MD_LAT - 1;
      end else if (x.ex_redirect) begin
         e = {1'b0, 1'b0, Z, Z, N, N};
         fl = 1'b1;
      end else if (x.load_use) begin
         e = {1'b1, 1'b0, K, Z, N, N};
      end
   endtask

   // One clock cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
   task automatic step(input in_t x, input bit use_tbl, input out_t tbl_exp, input string nm);
      out_t  e;
      out_t  act;
      bit    fl;
      @(negedge clk);
      {rst, mem_req, mem_ack, load_use, ex_md, ex_redirect, trap} = x;
      model(x, e, fl);
      #1;
      act = {pc_hold, md_done, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb};
      if (use_tbl) chk({nm, " table"}, 32'(act), 32'(tbl_exp));
      chk({nm, " model"}, 32'(act), 32'(e));
`ifdef PIPE_CTRL_PERF_EN
      chk({nm, " perf_stall"}, perf_stall_cnt, x.rst ? 32'd0 : m_stall);
      chk({nm, " perf_flush"}, perf_flush_cnt, x.rst ? 32'd0 : m_flush);
`else
      chk({nm, " perf_stall"}, perf_stall_cnt, 32'd0);
      chk({nm, " perf_flush"}, perf_flush_cnt, 32'd0);
`endif
      @(posedge clk);
      m_mem_wait = nx_mem_wait;
      m_drain    = nx_drain;
      m_md_left  = nx_md_left;
      if (x.rst) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         m_stall = m_stall + 32'(e.pc_hold);
         m_flush = m_flush + 32'(fl);
      end
   endtask

   function automatic vec_t mk(input logic r, mq, ma, lu, md, rd, tr,
                               input logic ph, dn, input logic [1:0] a, b, c, d);
      mk.in  = {r, mq, ma, lu, md, rd, tr};
      mk.exp = {ph, dn, a, b, c, d};
   endfunction

   initial begin
      vec_t tbl[$];
      in_t  x;
      {rst, mem_req, mem_ack, load_use, ex_md, ex_redirect, trap} = 7'b1000000;

      //                rst mq ma lu md rd tr   ph dn  if id ex wb
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   1, 0,  Z, Z, Z, Z)); // reset
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   1, 0,  Z, Z, Z, Z));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  N, N, N, N)); // idle
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,   1, 0,  K, Z, N, N)); // load-use
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,   0, 0,  Z, Z, N, N)); // redirect beats load-use
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   1, 0,  K, K, K, Z)); // bus wait x3
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   1, 0,  K, K, K, Z));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   1, 0,  K, K, K, Z));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0, 0,  N, N, N, N)); // ack
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N)); // mul/div issue
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 1,  N, N, N, N)); // md_done
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  N, N, N, N));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   1, 0,  K, K, K, Z)); // enter bus wait
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,   0, 0,  Z, Z, Z, Z)); // trap -> drain
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   1, 0,  Z, Z, Z, Z));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,   1, 0,  Z, Z, Z, Z)); // drain ack
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  N, N, N, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N)); // md then reset
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,   1, 0,  Z, Z, Z, Z));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  N, N, N, N)); // no md_done
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1,   0, 0,  Z, Z, Z, Z)); // trap with ack -> RUN
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0,   1, 0,  K, K, K, Z)); // mem beats md
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0,   0, 0,  N, N, N, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   1, 0,  K, K, Z, N)); // md beats redirect
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 1,  N, N, N, N));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0,  K, K, Z, N)); // trap in md wait
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0,  Z, Z, Z, Z));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  N, N, N, N));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));

`ifdef PIPE_CTRL_PERF_EN
      // Stall counter wrap: preload near all-ones, then two stall cycles.
      @(negedge clk);
      force dut.r_perf_stall = 32'hFFFF_FFFE;
      #1 release dut.r_perf_stall;
      m_stall = 32'hFFFF_FFFE;
      step(7'b0001000, 1'b0, '0, "wrap1");
      step(7'b0001000, 1'b0, '0, "wrap2");
      step(7'b0000000, 1'b0, '0, "wrap3");
      chk("wrap_value", perf_stall_cnt, 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         x.rst         = ($urandom_range(0, 59) == 0);
         x.mem_req     = ($urandom_range(0, 3) == 0);
         x.mem_ack     = ($urandom_range(0, 2) == 0);
         x.load_use    = ($urandom_range(0, 3) == 0);
         x.ex_md       = ($urandom_range(0, 5) == 0);
         x.ex_redirect = ($urandom_range(0, 4) == 0);
         x.trap        = ($urandom_range(0, 29) == 0);
         step(x, 1'b0, '0, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
